// File: rtl/pong_round_controller.sv
// pong_round_controller: frame-timed serve/play/point/gameover sequencer with score keeping; ROUND_CTRL_AUTORESTART_EN selects timed auto-restart from GAMEOVER.
module pong_round_controller #(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE = 5,
  parameter int GAMEOVER_FRAMES = 180
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       screenEnd,
  input  logic       start,
  input  logic [2:0] winner,
  output logic       play_en,
  output logic       ball_reset,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
  output logic       game_over,
  output logic [2:0] seg_digit,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, GAMEOVER = 3'd4} state_t;
  state_t state, state_n;
  logic [7:0] frame_cnt, cnt_n;
  logic [2:0] p1_n, p2_n, seg_n;
  logic screenEnd_q, frame_tick, last_tick, last_p2, last_n;
  assign frame_tick = screenEnd & ~screenEnd_q;
  assign last_tick = frame_tick & (frame_cnt <= 8'd1);
  assign state_dbg = state;
`ifndef ROUND_CTRL_AUTORESTART_EN
  logic start_q;
  always_ff @(posedge clk25) start_q <= reset ? 1'b0 : start;
`endif
  always_comb begin
    state_n = state;
    cnt_n = frame_cnt;
    p1_n = p1_score;
    p2_n = p2_score;
    last_n = last_p2;
    case (state)
      IDLE: begin
        p1_n = '0;
        p2_n = '0;
        if (start) begin
          state_n = SERVE;
          cnt_n = 8'(SERVE_FRAMES);
        end
      end
      SERVE: begin
        if (last_tick) state_n = (winner == 3'd0) ? PLAY : SERVE;
        else if (frame_tick) cnt_n = frame_cnt - 8'd1;
      end
      PLAY: begin
        if (winner == 3'd1 || winner == 3'd2) begin
          state_n = POINT;
          cnt_n = 8'(POINT_FRAMES);
          last_n = winner[1];
          p1_n = winner[1] ? p1_score : p1_score + 3'd1;
          p2_n = winner[1] ? p2_score + 3'd1 : p2_score;
        end
      end
      POINT: begin
        if (last_tick) begin
          state_n = (p1_score == 3'(WIN_SCORE) || p2_score == 3'(WIN_SCORE)) ? GAMEOVER : SERVE;
          cnt_n = (state_n == GAMEOVER) ? 8'(GAMEOVER_FRAMES) : 8'(SERVE_FRAMES);
        end else if (frame_tick) cnt_n = frame_cnt - 8'd1;
      end
      GAMEOVER: begin
`ifdef ROUND_CTRL_AUTORESTART_EN
        if (last_tick) begin
          state_n = SERVE;
          cnt_n = 8'(SERVE_FRAMES);
          p1_n = '0;
          p2_n = '0;
        end else if (frame_tick) cnt_n = frame_cnt - 8'd1;
`else
        if (start & ~start_q) begin
          state_n = IDLE;
          p1_n = '0;
          p2_n = '0;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  assign seg_n = (state_n == GAMEOVER) ? ((p1_n == 3'(WIN_SCORE)) ? 3'd1 : 3'd2) :
                 (state_n == POINT && last_n) ? p2_n : p1_n;
  always_ff @(posedge clk25) begin
    if (reset) begin
      state <= IDLE;
      frame_cnt <= '0;
      screenEnd_q <= 1'b0;
      p1_score <= '0;
      p2_score <= '0;
      last_p2 <= 1'b0;
      play_en <= 1'b0;
      ball_reset <= 1'b1;
      game_over <= 1'b0;
      seg_digit <= '0;
    end else begin
      state <= state_n;
      frame_cnt <= cnt_n;
      screenEnd_q <= screenEnd;
      p1_score <= p1_n;
      p2_score <= p2_n;
      last_p2 <= last_n;
      play_en <= state_n == PLAY;
      ball_reset <= state_n != PLAY;
      game_over <= state_n == GAMEOVER;
      seg_digit <= seg_n;
    end
  end
endmodule

// File: tb/tb_pong_round_controller.sv
// tb_pong_round_controller: directed vectors feed an expectation queue drained by a negedge monitor.
module tb_pong_round_controller;
  logic clk25 = 1'b0, reset = 1'b1, screenEnd = 1'b0, start = 1'b0;
  logic [2:0] winner = 3'd0;
  logic play_en, ball_reset, game_over;
  logic [2:0] p1_score, p2_score, seg_digit, state_dbg;
  int checks = 0, fails = 0;
  typedef struct {
    string name;
    logic [2:0] st;
    logic [2:0] p1;
    logic [2:0] p2;
    logic [2:0] seg;
  } exp_t;
  exp_t sb[$];
  pong_round_controller #(.SERVE_FRAMES(3), .POINT_FRAMES(2), .WIN_SCORE(2), .GAMEOVER_FRAMES(2)) dut (
    .clk25(clk25), .reset(reset), .screenEnd(screenEnd), .start(start), .winner(winner),
    .play_en(play_en), .ball_reset(ball_reset), .p1_score(p1_score), .p2_score(p2_score),
    .game_over(game_over), .seg_digit(seg_digit), .state_dbg(state_dbg));
  always #5 clk25 = ~clk25;
  task automatic step();
    @(posedge clk25);
    #1;
  endtask
  task automatic tick();
    screenEnd = 1'b1;
    step();
    screenEnd = 1'b0;
    step();
  endtask
  task automatic expect_out(input string n, input logic [2:0] st, input logic [2:0] p1, input logic [2:0] p2, input logic [2:0] seg);
    sb.push_back('{n, st, p1, p2, seg});
  endtask
  always @(negedge clk25) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [14:0] got, want;
      e = sb.pop_front();
      got = {state_dbg, p1_score, p2_score, play_en, ball_reset, game_over, seg_digit};
      want = {e.st, e.p1, e.p2, e.st == 3'd2, e.st != 3'd2, e.st == 3'd4, e.seg};
      checks++;
      if (got !== want) begin
        fails++;
        $display("FAIL %s: got st=%0d p1=%0d p2=%0d play_en=%0b ball_reset=%0b game_over=%0b seg=%0d, expected st=%0d p1=%0d p2=%0d play_en=%0b ball_reset=%0b game_over=%0b seg=%0d",
                 e.name, state_dbg, p1_score, p2_score, play_en, ball_reset, game_over, seg_digit,
                 e.st, e.p1, e.p2, e.st == 3'd2, e.st != 3'd2, e.st == 3'd4, e.seg);
      end
    end
  end
  initial begin
    #200000;
    checks++;
    fails++;
    $display("FAIL timeout: stimulus did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
  initial begin
    step();
    step();
    checks++;
    if ({state_dbg, p1_score, p2_score, play_en, ball_reset, game_over, seg_digit} !== {3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0}) begin
      fails++;
      $display("FAIL reset_state: st=%0d p1=%0d p2=%0d play_en=%0b ball_reset=%0b game_over=%0b seg=%0d",
               state_dbg, p1_score, p2_score, play_en, ball_reset, game_over, seg_digit);
    end
    reset = 1'b0;
    expect_out("reset", 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    expect_out("idle_no_start", 3'd0, 3'd0, 3'd0, 3'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    expect_out("start_serve", 3'd1, 3'd0, 3'd0, 3'd0);
    tick();
    expect_out("serve_t1", 3'd1, 3'd0, 3'd0, 3'd0);
    tick();
    expect_out("serve_t2", 3'd1, 3'd0, 3'd0, 3'd0);
    tick();
    expect_out("serve_done", 3'd2, 3'd0, 3'd0, 3'd0);
    winner = 3'd3;
    step();
    winner = 3'd7;
    step();
    winner = 3'd0;
    expect_out("winner_ignored", 3'd2, 3'd0, 3'd0, 3'd0);
    tick();
    expect_out("play_tick_ignored", 3'd2, 3'd0, 3'd0, 3'd0);
    winner = 3'd2;
    repeat (5) step();
    winner = 3'd0;
    expect_out("p2_point_once", 3'd3, 3'd0, 3'd1, 3'd1);
    tick();
    expect_out("point_t1", 3'd3, 3'd0, 3'd1, 3'd1);
    tick();
    expect_out("point_done", 3'd1, 3'd0, 3'd1, 3'd0);
    repeat (3) tick();
    expect_out("serve2_done", 3'd2, 3'd0, 3'd1, 3'd0);
    screenEnd = 1'b1;
    winner = 3'd1;
    step();
    screenEnd = 1'b0;
    winner = 3'd0;
    expect_out("p1_coincident", 3'd3, 3'd1, 3'd1, 3'd1);
    step();
    tick();
    expect_out("coinc_t1", 3'd3, 3'd1, 3'd1, 3'd1);
    tick();
    expect_out("coinc_t2", 3'd1, 3'd1, 3'd1, 3'd1);
    repeat (3) tick();
    expect_out("serve3_done", 3'd2, 3'd1, 3'd1, 3'd1);
    winner = 3'd1;
    step();
    winner = 3'd0;
    expect_out("p1_win_point", 3'd3, 3'd2, 3'd1, 3'd2);
    tick();
    expect_out("win_point_t1", 3'd3, 3'd2, 3'd1, 3'd2);
    tick();
    expect_out("gameover", 3'd4, 3'd2, 3'd1, 3'd1);
`ifdef ROUND_CTRL_AUTORESTART_EN
    winner = 3'd2;
    start = 1'b1;
    step();
    winner = 3'd0;
    start = 1'b0;
    expect_out("go_frozen", 3'd4, 3'd2, 3'd1, 3'd1);
    tick();
    expect_out("go_t1", 3'd4, 3'd2, 3'd1, 3'd1);
    tick();
    expect_out("auto_serve", 3'd1, 3'd0, 3'd0, 3'd0);
`else
    repeat (3) tick();
    winner = 3'd2;
    step();
    winner = 3'd0;
    expect_out("go_hold", 3'd4, 3'd2, 3'd1, 3'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    expect_out("restart_idle", 3'd0, 3'd0, 3'd0, 3'd0);
    step();
    expect_out("idle_stays", 3'd0, 3'd0, 3'd0, 3'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    expect_out("new_serve", 3'd1, 3'd0, 3'd0, 3'd0);
`endif
    tick();
    tick();
    winner = 3'd1;
    tick();
    expect_out("serve_hold", 3'd1, 3'd0, 3'd0, 3'd0);
    tick();
    expect_out("serve_hold2", 3'd1, 3'd0, 3'd0, 3'd0);
    winner = 3'd0;
    tick();
    expect_out("hold_release", 3'd2, 3'd0, 3'd0, 3'd0);
    winner = 3'd1;
    step();
    winner = 3'd0;
    expect_out("p1_point_new", 3'd3, 3'd1, 3'd0, 3'd1);
    reset = 1'b1;
    screenEnd = 1'b1;
    winner = 3'd2;
    step();
    expect_out("reset_mid", 3'd0, 3'd0, 3'd0, 3'd0);
    reset = 1'b0;
    screenEnd = 1'b0;
    winner = 3'd0;
    step();
    expect_out("after_reset", 3'd0, 3'd0, 3'd0, 3'd0);
    step();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pong_round_controller.md
# pong_round_controller

Round sequencer for the two-player pong display. Sits between the VGA timing generator, the processor wrapper and the seven-segment decoder. It gates paddle/ball motion, holds the ball at its initial position between rallies, keeps both scores from the processor's `winner` code, and decides serve, point-pause and game-over timing on frame boundaries.

## Interface
Parameters:
- `SERVE_FRAMES`, 60: frame ticks the ball is held before a rally starts (1..255).
- `POINT_FRAMES`, 90: frame ticks of freeze after a point (1..255).
- `WIN_SCORE`, 5: score that ends the game (1..7).
- `GAMEOVER_FRAMES`, 180: frame ticks shown before auto-restart (1..255). Used only with `ROUND_CTRL_AUTORESTART_EN`.

Ports:
- `clk25` in 1: 25 MHz pixel clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `screenEnd` in 1: frame-end level from the timing generator, synchronous to `clk25`.
- `start` in 1: player start request, level, synchronous to `clk25`.
- `winner` in 3: processor round result. 0 = none, 1 = player 1 scored, 2 = player 2 scored, 3..7 = ignored.
- `play_en` out 1: high only in PLAY; enables paddle and ball updates.
- `ball_reset` out 1: high in every state except PLAY; processor reloads `ball_xinit`/`ball_yinit`.
- `p1_score`, `p2_score` out 3: current scores.
- `game_over` out 1: high in GAMEOVER.
- `seg_digit` out 3: number for `segment_decoder`.
- `state_dbg` out 3: encoded state, IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.

## Operation
- Frame tick: `frame_tick = screenEnd & ~screenEnd_q`, where `screenEnd_q` is `screenEnd` registered on `clk25`. It is one cycle wide per frame. `screenEnd_q` resets to 0.
- 8-bit `frame_cnt` is loaded with N on entry to a timed state. It decrements on each tick. The state exits on the tick where `frame_cnt==1`, i.e. exactly N ticks after entry.
- IDLE: scores are 0. When `start==1`, go to SERVE and load `SERVE_FRAMES`.
- SERVE: counts down. On the final tick:
  - if `winner==0`, go to PLAY;
  - otherwise hold in SERVE with `frame_cnt=1` and re-check on every following tick.
- PLAY: on any cycle with `winner==1`, increment `p1_score`; with `winner==2`, increment `p2_score`. In either case go to POINT and load `POINT_FRAMES`. Frame ticks are ignored in PLAY.
- POINT: counts down. On the final tick:
  - if either score equals `WIN_SCORE`, go to GAMEOVER;
  - otherwise go to SERVE and load `SERVE_FRAMES`.
- GAMEOVER: scores are frozen. Exit behaviour is set by the Configuration section.
- `winner` is ignored outside PLAY. A score increments at most once per PLAY entry.
- `seg_digit`:
  - GAMEOVER: winning player number (1 or 2).
  - POINT: score of the player who just scored.
  - all other states: `p1_score`.

## Timing
- All outputs are registered and reflect the new state one cycle after the transition edge.
- Latencies:
  - `winner` valid at edge k in PLAY → at edge k+1, `play_en=0`, `ball_reset=1` and the score is incremented.
  - `start` at edge k in IDLE → SERVE at k+1.
- Reset values: state IDLE, `play_en=0`, `ball_reset=1`, scores 0, `game_over=0`, `seg_digit=0`, `frame_cnt=0`, `screenEnd_q=0`.
- Reset asserted mid-game returns every output to its reset value at the next edge, regardless of `frame_tick` or `winner`.
- Simultaneous `winner!=0` and `frame_tick` in PLAY: the point is taken, and the tick is not counted against `POINT_FRAMES`.
- `start` held high through a whole game does not skip SERVE. IDLE→SERVE occurs only from IDLE.
- Scores never exceed `WIN_SCORE` and never wrap.

## Configuration
- `ROUND_CTRL_AUTORESTART_EN` defined: GAMEOVER loads `GAMEOVER_FRAMES`. On its final tick, both scores clear and the state goes to SERVE with `SERVE_FRAMES` loaded. `start` is ignored in GAMEOVER.
- Not defined: GAMEOVER holds until `start` is seen low then high (rising edge, registered internally). It then clears both scores and goes to IDLE, not SERVE. `GAMEOVER_FRAMES` is unused.

## Test plan
- Reset, then `start=1` one cycle with `SERVE_FRAMES=3` → `ball_reset=1` for exactly 3 frame ticks. `play_en` rises one cycle after the 3rd tick.
- In PLAY, pulse `winner=2` for 5 cycles → `p2_score` goes 0→1 once. State goes to POINT. `seg_digit=1`. `p1_score` stays 0.
- `winner=3` and `winner=7` in PLAY → no state change, no score change.
- `winner=1` coincident with a frame tick, `POINT_FRAMES=2` → POINT lasts 2 subsequent ticks, then SERVE.
- `WIN_SCORE=2`, two player-1 points → GAMEOVER, `game_over=1`, `seg_digit=1`. Repeat with the macro defined (auto-restart to SERVE with 0/0 after `GAMEOVER_FRAMES`) and without it (holds until a `start` rising edge, then IDLE with 0/0).
- Assert `reset` for 1 cycle during POINT with score 3/1 → next cycle IDLE, scores 0, `ball_reset=1`, `play_en=0`.
